// File: rtl/pipe_register_chain.sv
// Pipeline register chain: DEPTH stages of W-bit data with per-stage valid bits,
// valid/ready backpressure, bubble collapsing and synchronous flush.
module pipe_register_chain #(
   parameter  int W     = 32,
   parameter  int DEPTH = 3,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] count
);

   logic [W-1:0]     data_p [DEPTH];
   logic [DEPTH-1:0] vld_p;
   logic [DEPTH-1:0] vld_nxt;
   logic [DEPTH-1:0] adv;
   logic             open_0;
   logic             acc;

   function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   // Advance terms ripple from the output back toward the input, so a stage
   // may move into an empty successor even while the output is stalled.
   always_comb begin
      logic down_open;
      down_open = out_ready;
      adv       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         adv[i]    = vld_p[i] & down_open;
         down_open = ~vld_p[i] | adv[i];
      end
      open_0 = down_open;
   end

   assign in_ready = open_0 & ~flush;
   assign acc      = in_valid & in_ready;

   always_comb begin
      vld_nxt = vld_p;
      if (acc)         vld_nxt[0] = 1'b1;
      else if (adv[0]) vld_nxt[0] = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         if (adv[i-1])    vld_nxt[i] = 1'b1;
         else if (adv[i]) vld_nxt[i] = 1'b0;
      end
      if (flush) vld_nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
         count <= '0;
      end else begin
         vld_p <= vld_nxt;
         count <= popcount(vld_nxt);
      end
   end

   // Stage data: loads only on a transfer into the stage; flush leaves it untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
      end else begin
         if (acc) data_p[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) data_p[i] <= data_p[i-1];
         end
      end
   end

   assign out_valid = vld_p[DEPTH-1];
   assign out_data  = data_p[DEPTH-1];

endmodule

// File: tb/tb_pipe_register_chain.sv
// Directed bench for pipe_register_chain: streaming on a 3-deep chain, stall,
// bubble collapse, full pass-through, flush and async reset on a 4-deep chain.
module tb_pipe_register_chain;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;

   logic         flush3, in_valid3, in_ready3, out_valid3, out_ready3;
   logic [W-1:0] in_data3, out_data3;
   logic [1:0]   count3;

   logic         flush4, in_valid4, in_ready4, out_valid4, out_ready4;
   logic [W-1:0] in_data4, out_data4;
   logic [2:0]   count4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_register_chain #(.W(W), .DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .flush(flush3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .count(count3)
   );

   pipe_register_chain #(.W(W), .DEPTH(4)) u4 (
      .clk(clk), .rst(rst), .flush(flush4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .count(count4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
      flush4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_data",  out_data4, 32'd0);
      chk("rst_count",     32'(count4), 32'd0);
      chk("rst_in_ready",  32'(in_ready4), 32'd1);
      chk("rst_count3",    32'(count3), 32'd0);
      #10 rst = 1'b0;
      tick();

      // streaming through the 3-deep chain, word e accepted on edge e
      for (int e = 1; e <= 14; e++) begin
         in_valid3 = (e <= 10);
         in_data3  = 32'(e);
         #1 chk("stream_in_ready", 32'(in_ready3), 32'd1);
         tick();
         chk("stream_out_valid", 32'(out_valid3), 32'(e >= 3 && e <= 12));
         if (e >= 3 && e <= 12) chk("stream_out_data", out_data3, 32'(e - 2));
         if (e >= 3 && e <= 10) chk("stream_count", 32'(count3), 32'd3);
      end
      in_valid3 = 1'b0;

      // stall: fills completely before in_ready drops
      out_ready4 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid4 = 1'b1;
         in_data4  = 32'hAAAA0001 + 32'(c < 4 ? c : 4);
         #1 chk("stall_in_ready", 32'(in_ready4), 32'(c < 4));
         tick();
         chk("stall_count", 32'(count4), 32'(c < 3 ? c + 1 : 4));
         if (c >= 3) begin
            chk("stall_out_valid", 32'(out_valid4), 32'd1);
            chk("stall_out_data", out_data4, 32'hAAAA0001);
         end
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("drain_valid", 32'(out_valid4), 32'd1);
         chk("drain_data", out_data4, 32'hAAAA0001 + 32'(k));
         tick();
      end
      chk("drain_empty_valid", 32'(out_valid4), 32'd0);
      chk("drain_empty_count", 32'(count4), 32'd0);

      // bubbles: valid pattern 1,0,1,0,1,0 with output stalled
      out_ready4 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid4 = (c == 0 || c == 2 || c == 4);
         in_data4  = 32'hBBBB0000 + 32'(c / 2 + 1);
         tick();
      end
      in_valid4 = 1'b0;
      chk("bub_count", 32'(count4), 32'd3);
      chk("bub_out_valid", 32'(out_valid4), 32'd1);
      chk("bub_out_data", out_data4, 32'hBBBB0001);
      out_ready4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bub_drain_valid", 32'(out_valid4), 32'd1);
         chk("bub_drain_data", out_data4, 32'hBBBB0001 + 32'(k));
         tick();
      end
      chk("bub_empty_valid", 32'(out_valid4), 32'd0);
      chk("bub_empty_count", 32'(count4), 32'd0);

      // full chain with simultaneous accept and emit
      out_ready4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1'b1;
         in_data4  = 32'hCCCC0001 + 32'(k);
         tick();
      end
      in_valid4 = 1'b1;
      in_data4  = 32'hCCCC0005;
      #1;
      chk("full_count", 32'(count4), 32'd4);
      chk("full_in_ready", 32'(in_ready4), 32'd0);
      out_ready4 = 1'b1;
      #1 chk("pass_in_ready", 32'(in_ready4), 32'd1);
      tick();
      in_valid4 = 1'b0;
      out_ready4 = 1'b0;
      chk("pass_count", 32'(count4), 32'd4);
      chk("pass_out_data", out_data4, 32'hCCCC0002);
      out_ready4 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk("pass_drain_data", out_data4, 32'hCCCC0002 + 32'(k));
         tick();
      end
      chk("pass_empty_count", 32'(count4), 32'd0);

      // flush with two words held and in_valid asserted
      out_ready4 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid4 = 1'b1;
         in_data4  = 32'hF0F00001 + 32'(k);
         tick();
      end
      chk("flush_pre_count", 32'(count4), 32'd2);
      flush4 = 1'b1;
      in_valid4 = 1'b1;
      in_data4 = 32'h55;
      #1 chk("flush_in_ready", 32'(in_ready4), 32'd0);
      tick();
      flush4 = 1'b0;
      in_valid4 = 1'b0;
      chk("flush_count", 32'(count4), 32'd0);
      chk("flush_out_valid", 32'(out_valid4), 32'd0);
      in_valid4 = 1'b1;
      in_data4 = 32'h55;
      out_ready4 = 1'b1;
      #1 chk("post_flush_in_ready", 32'(in_ready4), 32'd1);
      tick();
      in_valid4 = 1'b0;
      chk("post_flush_lat0", 32'(out_valid4), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("post_flush_lat", 32'(out_valid4), 32'(k == 3));
         if (k == 3) chk("post_flush_data", out_data4, 32'h55);
      end
      tick();
      chk("post_flush_empty", 32'(count4), 32'd0);

      // asynchronous reset between edges while full and stalled
      out_ready4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1'b1;
         in_data4  = 32'hDDDD0001 + 32'(k);
         tick();
      end
      in_data4 = 32'hDDDD0005;
      chk("arst_pre_count", 32'(count4), 32'd4);
      chk("arst_pre_valid", 32'(out_valid4), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid4), 32'd0);
      chk("arst_out_data", out_data4, 32'd0);
      chk("arst_count", 32'(count4), 32'd0);
      chk("arst_in_ready", 32'(in_ready4), 32'd1);
      #1 rst = 1'b0;
      in_valid4 = 1'b0;
      #1 chk("arst_post_in_ready", 32'(in_ready4), 32'd1);
      tick();
      chk("arst_post_count", 32'(count4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
